// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT types and helpers (log2, width-parameterised bit reversal, reorder FSM states)
package fft_pkg;
  typedef enum logic {IDLE, READ} state_t;
  function automatic int log2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return r;
  endfunction
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r = (i < w) ? {r[30:0], 1'(v >> i)} : r;
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: 2^AW x DW simple dual-port RAM; ports clock, we/wa/wd sync write, ra in, rd registered read data out
module fft_reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong bit-reversed to natural order frame buffer; ports clock, reset, di_en/di_re/di_im in, do_en/do_re/do_im/do_index out
module fft_reorder
  import fft_pkg::*;
#(
  parameter int N = 64,
  parameter int WIDTH = 16,
  localparam int LN = log2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LN-1:0]    do_index
);
  logic [LN-1:0] wr_count, rd_count, idx1, wr_addr;
  logic wr_bank, rd_bank, v1, last_wr, last_rd;
  logic [1:0] full;
  state_t state;
  logic [2*WIDTH-1:0] rd_data;
  assign wr_addr = LN'(bitrev(32'(wr_count), LN));
  assign last_wr = di_en && wr_count == LN'(N - 1);
  assign last_rd = state == READ && rd_count == LN'(N - 1);
  fft_reorder_ram #(.AW(LN + 1), .DW(2 * WIDTH)) ram (
    .clock(clock),
    .we(di_en && !reset),
    .wa({wr_bank, wr_addr}),
    .wd({di_re, di_im}),
    .ra({rd_bank, rd_count}),
    .rd(rd_data)
  );
  // v1/idx1 track the read issued last cycle so they line up with the registered RAM output
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full     <= 2'b00;
      state    <= IDLE;
      v1       <= 1'b0;
      idx1     <= '0;
      do_en    <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
      do_index <= '0;
    end else begin
      if (di_en) wr_count <= wr_count + 1'b1;
      if (last_wr) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
      end
      v1   <= state == READ;
      idx1 <= rd_count;
      if (state == IDLE) begin
        if (full[rd_bank]) begin
          state    <= READ;
          rd_count <= '0;
        end
      end else begin
        rd_count <= rd_count + 1'b1;
        if (last_rd) begin
          full[rd_bank] <= 1'b0;
          rd_bank <= ~rd_bank;
          if (!full[!rd_bank]) state <= IDLE;
        end
      end
      do_en <= v1;
      if (v1) begin
        do_re    <= rd_data[2*WIDTH-1:WIDTH];
        do_im    <= rd_data[WIDTH-1:0];
        do_index <= idx1;
      end
    end
  end
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: randomized scoreboard bench for fft_reorder at N=64/WIDTH=16 and N=16/WIDTH=12
module tb_fft_reorder;
  localparam int N = 64, W = 16, LN = 6, N2 = 16, W2 = 12, LN2 = 4;
  typedef struct {int re; int im; int idx;} exp_t;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic di_en = 1'b0, do_en;
  logic [W-1:0] di_re = '0, di_im = '0, do_re, do_im;
  logic [LN-1:0] do_index;
  logic di_en_s = 1'b0, do_en_s;
  logic [W2-1:0] di_re_s = '0, di_im_s = '0, do_re_s, do_im_s;
  logic [LN2-1:0] do_index_s;
  exp_t sb[$], sb_s[$], e64, e16;
  int lat_q[$], run_q[$];
  int passed = 0, total = 0, cyc = 0, run = 0;
  bit flushing = 1'b0;

  fft_reorder #(.N(N), .WIDTH(W)) dut (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_index(do_index)
  );
  fft_reorder #(.N(N2), .WIDTH(W2)) dut_s (
    .clock(clock), .reset(reset), .di_en(di_en_s), .di_re(di_re_s), .di_im(di_im_s),
    .do_en(do_en_s), .do_re(do_re_s), .do_im(do_im_s), .do_index(do_index_s)
  );

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int rev(input int v, input int b);
    int r = 0;
    for (int i = 0; i < b; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  always @(negedge clock) begin
    if (flushing) run = 0;
    else if (do_en) begin
      if (run == 0) begin
        if (lat_q.size() == 0) chk("unexpected_start", cyc, -1);
        else chk("latency", cyc, lat_q.pop_front());
      end
      run++;
      if (sb.size() == 0) chk("unexpected_out", int'(do_index), -1);
      else begin
        e64 = sb.pop_front();
        chk("re", int'(do_re), e64.re);
        chk("im", int'(do_im), e64.im);
        chk("index", int'(do_index), e64.idx);
      end
    end else if (run > 0) begin
      if (run_q.size() == 0) chk("unexpected_run", run, -1);
      else chk("run_length", run, run_q.pop_front());
      run = 0;
    end
  end

  always @(negedge clock) begin
    if (!flushing && do_en_s) begin
      if (sb_s.size() == 0) chk("s_unexpected_out", int'(do_index_s), -1);
      else begin
        e16 = sb_s.pop_front();
        chk("s_re", int'(do_re_s), e16.re);
        chk("s_im", int'(do_im_s), e16.im);
        chk("s_index", int'(do_index_s), e16.idx);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      di_en = 1'b0;
    end
  endtask

  task automatic send_frame(input bit gap, input bit rnd, input bit lat, input int runlen, input int cnt);
    int re[N], im[N];
    for (int k = 0; k < N; k++) begin
      re[k] = rnd ? int'($urandom_range(0, 65535)) : rev(k, LN);
      im[k] = rnd ? int'($urandom_range(0, 65535)) : (-rev(k, LN)) & 16'hFFFF;
    end
    if (cnt == N)
      for (int b = 0; b < N; b++) sb.push_back('{re[rev(b, LN)], im[rev(b, LN)], b});
    if (runlen > 0) run_q.push_back(runlen);
    for (int k = 0; k < cnt; k++) begin
      @(posedge clock); #1;
      di_en = 1'b1;
      di_re = W'(re[k]);
      di_im = W'(im[k]);
      if (lat && k == cnt - 1) lat_q.push_back(cyc + 4);
      if (gap && k < cnt - 1) begin
        @(posedge clock); #1;
        di_en = 1'b0;
      end
    end
  endtask

  task automatic send_s();
    int re[N2], im[N2];
    for (int k = 0; k < N2; k++) begin
      re[k] = int'($urandom_range(0, 4095));
      im[k] = int'($urandom_range(0, 4095));
    end
    for (int b = 0; b < N2; b++) sb_s.push_back('{re[rev(b, LN2)], im[rev(b, LN2)], b});
    for (int k = 0; k < N2; k++) begin
      @(posedge clock); #1;
      di_en_s = 1'b1;
      di_re_s = W2'(re[k]);
      di_im_s = W2'(im[k]);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
        di_en_s = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && (sb.size() > 0 || run_q.size() > 0); i++) @(posedge clock);
    chk("drain_pending", sb.size() + run_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_do_en", int'(do_en), 0);
    chk("reset_do_re", int'(do_re), 0);
    chk("reset_do_im", int'(do_im), 0);
    chk("reset_do_index", int'(do_index), 0);
    chk("reset_s_do_en", int'(do_en_s), 0);
    reset = 1'b0;
    send_frame(1'b0, 1'b0, 1'b1, N, N);
    idle(1);
    wait_drain();
    idle(100);
    chk("idle_do_en", int'(do_en), 0);
    chk("hold_index", int'(do_index), N - 1);
    chk("hold_re", int'(do_re), N - 1);
    chk("hold_im", int'(do_im), (-(N - 1)) & 16'hFFFF);
    send_frame(1'b0, 1'b1, 1'b1, 3 * N, N);
    send_frame(1'b0, 1'b1, 1'b0, 0, N);
    send_frame(1'b0, 1'b1, 1'b0, 0, N);
    idle(1);
    wait_drain();
    send_frame(1'b1, 1'b1, 1'b1, N, N);
    idle(1);
    wait_drain();
    send_frame(1'b0, 1'b1, 1'b1, N, N);
    send_frame(1'b0, 1'b1, 1'b0, 0, 20);
    @(posedge clock); #1;
    flushing = 1'b1;
    reset = 1'b1;
    di_en = 1'b0;
    @(posedge clock); #1;
    chk("midreset_do_en", int'(do_en), 0);
    chk("midreset_do_re", int'(do_re), 0);
    chk("midreset_do_im", int'(do_im), 0);
    chk("midreset_do_index", int'(do_index), 0);
    reset = 1'b0;
    sb.delete();
    lat_q.delete();
    run_q.delete();
    flushing = 1'b0;
    send_frame(1'b0, 1'b1, 1'b1, N, N);
    idle(1);
    wait_drain();
    repeat (3) send_s();
    @(posedge clock); #1;
    di_en_s = 1'b0;
    for (int i = 0; i < 2000 && sb_s.size() > 0; i++) @(posedge clock);
    chk("s_drain_pending", sb_s.size(), 0);
    idle(5);
    chk("lat_pending", lat_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
